// File: rtl/rx_frame_decoder.sv
// rx_frame_decoder: 8x-oversampled receiver for 22-bit monitoring-link frames (type, data, odd parity).
// Optional macro RX_CONFIRM_EN: a word is reported only once a matching repeat frame arrives in the window.
module rx_frame_decoder #(
  parameter int OVERSAMPLE  = 8,
  parameter int CONFIRM_WIN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  output logic [15:0] fre_data,
  output logic [15:0] volt,
  output logic [15:0] state,
  output logic        fre_vld,
  output logic        volt_vld,
  output logic        state_vld,
  output logic        fault_vld,
  output logic        parity_err,
  output logic        frame_err,
  output logic [2:0]  dbg_state
);

  localparam int              PH_W      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [PH_W-1:0] PH_MID    = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(OVERSAMPLE - 1);
  localparam logic [4:0]      LAST_BIT  = 5'd20;
  localparam logic [4:0]      T_VOLT    = 5'b00001;
  localparam logic [4:0]      T_FRE     = 5'b00010;
  localparam logic [4:0]      T_STATE   = 5'b00100;
  localparam logic [4:0]      T_FAULT   = 5'b00101;
  localparam logic [15:0]     FAULT_PAT = 16'hE5E5;
  localparam bit              CFG_OK    = (OVERSAMPLE >= 4) && (CONFIRM_WIN >= 2);

  if (!CFG_OK) begin : g_cfg_check
    $error("rx_frame_decoder: OVERSAMPLE must be >= 4 and CONFIRM_WIN >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_CHECK  = 3'd4
  } fsm_t;

  fsm_t            cur;
  logic            rx_m;
  logic            rx_s;
  logic            rx_d;
  logic [PH_W-1:0] phase;
  logic [4:0]      bitcnt;
  logic [20:0]     shreg;
  logic            par_bit;
  logic [4:0]      f_type;
  logic [15:0]     f_data;
  logic            par_ok;
  logic            frm_ok;
  logic            do_report;

  // Sync flops idle high so a reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rxd;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign f_type    = shreg[20:16];
  assign f_data    = shreg[15:0];
  assign par_ok    = ^{shreg, par_bit};
  assign dbg_state = cur;

  always_comb begin
    frm_ok = 1'b0;
    case (f_type)
      T_VOLT, T_FRE, T_STATE: frm_ok = 1'b1;
      T_FAULT:                frm_ok = (f_data == FAULT_PAT);
      default:                frm_ok = 1'b0;
    endcase
  end

`ifdef RX_CONFIRM_EN
  localparam int WC_W = $clog2(CONFIRM_WIN + 1);

  logic            pend_vld;
  logic            pend_rep;
  logic [20:0]     pend_key;
  logic [WC_W-1:0] win_cnt;
  logic            key_hit;

  assign key_hit   = pend_vld && (pend_key == shreg);
  assign do_report = par_ok && frm_ok && key_hit && !pend_rep;

  // Window counts only idle clocks; every evaluated frame restarts it, error frames leave the slot alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_rep <= 1'b0;
      pend_key <= '0;
      win_cnt  <= '0;
    end else if (cur == S_CHECK) begin
      win_cnt <= '0;
      if (par_ok && frm_ok) begin
        if (key_hit) begin
          pend_rep <= 1'b1;
        end else begin
          pend_vld <= 1'b1;
          pend_key <= shreg;
          pend_rep <= 1'b0;
        end
      end
    end else if (cur == S_IDLE && pend_vld) begin
      if (win_cnt == WC_W'(CONFIRM_WIN - 1)) begin
        pend_vld <= 1'b0;
        pend_rep <= 1'b0;
        win_cnt  <= '0;
      end else begin
        win_cnt <= win_cnt + WC_W'(1);
      end
    end
  end
`else
  assign do_report = par_ok && frm_ok;
`endif

  // Pulses are one clock wide and cleared by default every cycle; words change only with their pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= S_IDLE;
      phase      <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      fre_data   <= '0;
      volt       <= '0;
      state      <= '0;
      fre_vld    <= 1'b0;
      volt_vld   <= 1'b0;
      state_vld  <= 1'b0;
      fault_vld  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      fre_vld    <= 1'b0;
      volt_vld   <= 1'b0;
      state_vld  <= 1'b0;
      fault_vld  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (cur)
        S_IDLE: begin
          phase  <= '0;
          bitcnt <= '0;
          if (rx_d && !rx_s) cur <= S_START;
        end
        S_START: begin
          if (phase == PH_MID) begin
            phase <= '0;
            if (!rx_s) begin
              shreg  <= {shreg[19:0], rx_s};
              bitcnt <= 5'd1;
              cur    <= S_DATA;
            end else begin
              cur <= S_IDLE;
            end
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        S_DATA: begin
          if (phase == PH_LAST) begin
            phase  <= '0;
            shreg  <= {shreg[19:0], rx_s};
            bitcnt <= bitcnt + 5'd1;
            if (bitcnt == LAST_BIT) cur <= S_PARITY;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        S_PARITY: begin
          if (phase == PH_LAST) begin
            phase   <= '0;
            par_bit <= rx_s;
            cur     <= S_CHECK;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        S_CHECK: begin
          cur    <= S_IDLE;
          bitcnt <= '0;
          // Parity is judged first so a corrupted frame never also reports a type error.
          if (!par_ok) begin
            parity_err <= 1'b1;
          end else if (!frm_ok) begin
            frame_err <= 1'b1;
          end else if (do_report) begin
            case (f_type)
              T_VOLT: begin
                volt     <= f_data;
                volt_vld <= 1'b1;
              end
              T_FRE: begin
                fre_data <= f_data;
                fre_vld  <= 1'b1;
              end
              T_STATE: begin
                state     <= f_data;
                state_vld <= 1'b1;
              end
              T_FAULT: fault_vld <= 1'b1;
              default: ;
            endcase
          end
        end
        default: cur <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Bench for rx_frame_decoder: vector table, directed corner sequences and random frames vs a frame-level model.
module tb_rx_frame_decoder;

  localparam int         W        = 19;
  localparam int         SHORT    = 24;
  localparam int         LONG     = 120;
  localparam logic [2:0] K_VOLT   = 3'd1;
  localparam logic [2:0] K_FRE    = 3'd2;
  localparam logic [2:0] K_STATE  = 3'd3;
  localparam logic [2:0] K_FAULT  = 3'd4;
  localparam logic [2:0] K_PERR   = 3'd5;
  localparam logic [2:0] K_FERR   = 3'd6;
  localparam logic [2:0] K_MULTI  = 3'd7;
  localparam logic [2:0] DBG_IDLE = 3'd0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] fre_data, volt, state;
  logic        fre_vld, volt_vld, state_vld, fault_vld, parity_err, frame_err;
  logic [2:0]  dbg_state;

  rx_frame_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .fre_data   (fre_data),
    .volt       (volt),
    .state      (state),
    .fre_vld    (fre_vld),
    .volt_vld   (volt_vld),
    .state_vld  (state_vld),
    .fault_vld  (fault_vld),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          fall_cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];
  int           act_cyc_q[$];
  logic [15:0]  ref_fre   = '0;
  logic [15:0]  ref_volt  = '0;
  logic [15:0]  ref_state = '0;
  logic         pend_v    = 1'b0;
  logic         pend_rep  = 1'b0;
  logic [20:0]  pend_key  = '0;

  typedef struct {
    logic [4:0]  t;
    logic [15:0] d;
    bit          flip;
    int          reps;
    logic [2:0]  kind;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every wait goes through tick, which also records any output pulse seen in that clock.
  task automatic tick();
    int n;
    logic [W-1:0] ev;
    @(negedge clk);
    cyc++;
    n = int'(volt_vld) + int'(fre_vld) + int'(state_vld) + int'(fault_vld)
      + int'(parity_err) + int'(frame_err);
    if (n > 0) begin
      if (n > 1)           ev = {K_MULTI, 16'h0000};
      else if (volt_vld)   ev = {K_VOLT, volt};
      else if (fre_vld)    ev = {K_FRE, fre_data};
      else if (state_vld)  ev = {K_STATE, state};
      else if (fault_vld)  ev = {K_FAULT, 16'h0000};
      else if (parity_err) ev = {K_PERR, 16'h0000};
      else                 ev = {K_FERR, 16'h0000};
      act_q.push_back(ev);
      act_cyc_q.push_back(cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_frame(input logic [4:0] t, input logic [15:0] d, input bit flip,
                            input int nbits, input int gap);
    logic [21:0] bits;
    bits = {t, d, (~^{t, d}) ^ flip};
    fall_cyc = cyc + 1;
    for (int i = 0; i < nbits; i++) begin
      rxd = bits[21-i];
      repeat (8) tick();
    end
    rxd = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic check_frame(input string name);
    logic [W-1:0] e, a;
    int c, lat;
    check({name, "_event_count"}, act_q.size(), exp_q.size());
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      c = act_cyc_q.pop_front();
      check({name, "_event"}, a, e);
      lat = c - fall_cyc;
      n_checks++;
      if (lat < 174 || lat > 176) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d clocks, expected 175+-1", name, lat);
      end
    end
    exp_q.delete();
    act_q.delete();
    act_cyc_q.delete();
  endtask

  task automatic check_words(input string name);
    check({name, "_fre_data"}, fre_data, ref_fre);
    check({name, "_volt"}, volt, ref_volt);
    check({name, "_state"}, state, ref_state);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] classify(input logic [4:0] t, input logic [15:0] d, input bit flip);
    logic p;
    p = (~^{t, d}) ^ flip;
    if ((^{t, d, p}) != 1'b1) return {K_PERR, 16'h0000};
    case (t)
      5'd1:    return {K_VOLT, d};
      5'd2:    return {K_FRE, d};
      5'd4:    return {K_STATE, d};
      5'd5:    return (d == 16'hE5E5) ? {K_FAULT, 16'h0000} : {K_FERR, 16'h0000};
      default: return {K_FERR, 16'h0000};
    endcase
  endfunction

  task automatic apply_word(input logic [W-1:0] ev);
    case (ev[18:16])
      K_VOLT:  ref_volt  = ev[15:0];
      K_FRE:   ref_fre   = ev[15:0];
      K_STATE: ref_state = ev[15:0];
      default: ;
    endcase
  endtask

  task automatic model_frame(input logic [4:0] t, input logic [15:0] d, input bit flip, input bit long_before);
    logic [W-1:0] ev;
    bit rep;
    ev  = classify(t, d, flip);
    rep = 1'b1;
    if (long_before) pend_v = 1'b0;
`ifdef RX_CONFIRM_EN
    if (ev[18:16] <= K_FAULT) begin
      if (pend_v && pend_key == {t, d}) begin
        rep      = !pend_rep;
        pend_rep = 1'b1;
      end else begin
        pend_v   = 1'b1;
        pend_key = {t, d};
        pend_rep = 1'b0;
        rep      = 1'b0;
      end
    end
`endif
    if (rep) begin
      exp_q.push_back(ev);
      apply_word(ev);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [4:0]  t;
    logic [15:0] d;
    bit flip, is_long, long_prev, saw_start, push;

    vecs[0] = '{t: 5'd1, d: 16'h1234, flip: 0, reps: 3, kind: K_VOLT,  exp_d: 16'h1234};
    vecs[1] = '{t: 5'd2, d: 16'hABCD, flip: 1, reps: 1, kind: K_PERR,  exp_d: 16'h0000};
    vecs[2] = '{t: 5'd4, d: 16'h5A5A, flip: 0, reps: 2, kind: K_STATE, exp_d: 16'h5A5A};
    vecs[3] = '{t: 5'd5, d: 16'hE5E5, flip: 0, reps: 6, kind: K_FAULT, exp_d: 16'h0000};
    vecs[4] = '{t: 5'd5, d: 16'hE5E4, flip: 0, reps: 6, kind: K_FERR,  exp_d: 16'h0000};
    vecs[5] = '{t: 5'd3, d: 16'h1111, flip: 0, reps: 1, kind: K_FERR,  exp_d: 16'h0000};
    vecs[6] = '{t: 5'd0, d: 16'h0000, flip: 0, reps: 1, kind: K_FERR,  exp_d: 16'h0000};
    vecs[7] = '{t: 5'd2, d: 16'hBEEF, flip: 0, reps: 2, kind: K_FRE,   exp_d: 16'hBEEF};
    vecs[8] = '{t: 5'd7, d: 16'h00FF, flip: 1, reps: 1, kind: K_PERR,  exp_d: 16'h0000};
    vecs[9] = '{t: 5'd1, d: 16'hFFFF, flip: 0, reps: 1, kind: K_VOLT,  exp_d: 16'hFFFF};

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check_words("reset");
    check("reset_pulses", {volt_vld, fre_vld, state_vld, fault_vld, parity_err, frame_err}, 6'b0);
    check("reset_fsm", dbg_state, DBG_IDLE);
    rst_n = 1'b1;
    repeat (4) tick();
    check_frame("post_reset");

    // Two-clock low glitch on an idle line
    saw_start = 1'b0;
    rxd = 1'b0;
    repeat (2) tick();
    rxd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dbg_state != DBG_IDLE) saw_start = 1'b1;
    end
    check("glitch_armed", saw_start, 1'b1);
    check("glitch_back_idle", dbg_state, DBG_IDLE);
    repeat (20) tick();
    check_frame("glitch");

    // Vector table
    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        push = 1'b1;
`ifdef RX_CONFIRM_EN
        if (vecs[i].kind <= K_FAULT && r != 1) push = 1'b0;
`endif
        if (push) begin
          exp_q.push_back({vecs[i].kind, vecs[i].exp_d});
          apply_word({vecs[i].kind, vecs[i].exp_d});
        end
        send_frame(vecs[i].t, vecs[i].d, vecs[i].flip, 22, (r == vecs[i].reps - 1) ? LONG : SHORT);
        check_frame("vec");
      end
      check_words("vec");
    end

    // Reset during bit 10 of a state frame, then a clean state frame
    send_frame(5'd4, 16'h0F0F, 1'b0, 10, 0);
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) tick();
    check("abort_fsm", dbg_state, DBG_IDLE);
    ref_fre = '0; ref_volt = '0; ref_state = '0; pend_v = 1'b0;
    check_words("abort_reset");
    rst_n = 1'b1;
    repeat (20) tick();
    check_frame("abort");
    model_frame(5'd4, 16'h0F0F, 1'b0, 1'b1);
    send_frame(5'd4, 16'h0F0F, 1'b0, 22, SHORT);
    check_frame("after_abort");
    model_frame(5'd4, 16'h0F0F, 1'b0, 1'b0);
    send_frame(5'd4, 16'h0F0F, 1'b0, 22, LONG);
    check_frame("after_abort_rep");
    check("after_abort_state", state, 16'h0F0F);
    check_words("after_abort");

    // Line stuck low: one all-zero frame (parity error), then nothing until the line recovers
    model_frame(5'd0, 16'h0000, 1'b1, 1'b1);
    fall_cyc = cyc + 1;
    rxd = 1'b0;
    repeat (400) tick();
    rxd = 1'b1;
    repeat (LONG) tick();
    check_frame("stuck_low");

    // Random frames against the model
    long_prev = 1'b1;
    t = 5'd1;
    d = 16'h0000;
    for (int i = 0; i < 24; i++) begin
      if (i == 0 || $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 5))
          0:       t = 5'd1;
          1:       t = 5'd2;
          2:       t = 5'd4;
          3:       t = 5'd5;
          default: t = 5'($urandom_range(0, 15));
        endcase
        d = 16'($urandom);
        if (t == 5'd5 && $urandom_range(0, 1) == 1) d = 16'hE5E5;
      end
      flip    = ($urandom_range(0, 4) == 0);
      is_long = ($urandom_range(0, 3) == 0);
      model_frame(t, d, flip, long_prev);
      send_frame(t, d, flip, 22, is_long ? LONG : SHORT);
      check_frame("rand");
      check_words("rand");
      long_prev = is_long;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_decoder.md
# rx_frame_decoder

Serial frame receiver for the monitoring link. It sits directly downstream of the frame sender, at the far end of the single-wire line. It samples the idle-high line with 8x oversampling, recovers 22-bit frames (5-bit type, 16-bit data, parity), and checks parity and type. It then presents the frequency, voltage and state words, plus fault indication, as registered words with one-clock valid pulses.

## Interface
- `OVERSAMPLE`, 8: clocks per bit. Must match the sender divider.
- `CONFIRM_WIN`, 64: clocks a pending frame waits in IDLE for its repeat. Used only with `RX_CONFIRM_EN`.
- `clk` input 1: sole clock. Same frequency as the sender clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `rxd` input 1: serial line. Idle 1. Asynchronous to `clk`.
- `fre_data` output 16: last accepted frequency word.
- `volt` output 16: last accepted voltage word.
- `state` output 16: last accepted state word.
- `fre_vld`, `volt_vld`, `state_vld`, `fault_vld` output 1 each: one-clock pulses marking a newly reported word or a fault.
- `parity_err` output 1: one-clock pulse when a frame fails the parity check.
- `frame_err` output 1: one-clock pulse when a frame has a bad type or a bad fault pattern.

## Operation
- `rxd` passes through a 2-flop synchroniser, giving `rx_s`. A third flop, `rx_d`, holds the previous `rx_s` for edge detection.
- Frame bit order: bit 20 first, MSB-first. Bits 20..16 are the type, bits 15..0 are the data, then the parity bit. Bit 20 is always 0 and serves as the start bit.
- Parity rule: XOR of the 21 frame bits and the parity bit must equal 1 (odd).
- Type codes:
  - 00001 = volt
  - 00010 = fre
  - 00100 = state
  - 00101 = fault; data must equal 16'hE5E5
  - any other type, or a fault frame with wrong data, raises `frame_err`.
- FSM states: IDLE, START, DATA, PARITY, CHECK. Counters: 3-bit `phase`, 5-bit `bitcnt`.
- IDLE -> START when `rx_d`=1 and `rx_s`=0. `phase` is cleared to 0.
- START: sample at `phase`==3.
  - If 0: shift into the shift register, `bitcnt`=1, go to DATA, clear `phase`.
  - If 1 (glitch): return to IDLE with no pulse.
- DATA: sample when `phase`==7 (8 clocks after the previous sample). Shift the bit in.
  - After `bitcnt` reaches 21, go to PARITY.
- PARITY: sample the parity bit at `phase`==7, then go to CHECK.
- CHECK lasts one clock. It evaluates parity, then type/pattern, in that order; a parity failure masks `frame_err`. It issues the result and returns to IDLE.
- Output words (`fre_data`, `volt`, `state`) update only in the cycle their `_vld` pulses. Otherwise they hold.
- No false start after a 0 parity bit: IDLE requires `rx_d`=1 before arming.

## Timing
- Reset values: all output words 0, all pulses 0, FSM IDLE, counters 0, pending slot empty.
- Start sample is 4 clocks after `rx_s` first reads 0. The parity sample is 168 clocks (21×8) after the start sample. The pulse is asserted the clock after the parity sample.
- Total latency from the `rxd` falling edge to the pulse is 175 clocks, ±1 for synchroniser phase.
- At most one `_vld`, `parity_err` or `frame_err` pulse per frame. All pulses are exactly 1 clock wide.
- Back-to-back sender slots give 32 clocks from the parity sample to the next start sample. The FSM is in IDLE ≥27 of those clocks.
- Reset mid-frame: immediate return to IDLE. The partial frame is discarded and no pulse is issued.
- Line stuck low: one START→DATA pass completes. Then IDLE waits for a return to 1; no repeated frames are produced.

## Configuration
- `RX_CONFIRM_EN` defined:
  - A valid frame is first stored as pending (type+data) and produces no pulse.
  - An idle-clock counter starts at CHECK. The pending slot clears after `CONFIRM_WIN` clocks without a new start.
  - A second valid frame with identical type+data inside the window reports the word once (`_vld` pulse) and marks the slot "reported".
  - Further identical frames inside the window are suppressed. Each one restarts the window.
  - A differing valid frame replaces the pending slot.
  - Parity or frame errors still pulse immediately and do not clear the slot.
  - Result: a 3-slot burst reports once, and a 6-slot fault burst gives one `fault_vld`.
- `RX_CONFIRM_EN` undefined: every valid frame reports immediately in CHECK. The pending logic is absent.

## Test plan
- Volt frame with data 16'h1234 and correct parity → `volt`=16'h1234, one `volt_vld` 175±1 clocks after the falling edge. Without `RX_CONFIRM_EN` this happens on frame 1; with it, on frame 2 of a 3-slot burst, and only once.
- Fre frame with data 16'hABCD and the parity bit inverted → one `parity_err`, no `fre_vld`, `fre_data` unchanged.
- Low glitch of 2 clocks on idle `rxd` → no pulses, FSM back in IDLE within 6 clocks.
- 6-slot fault burst (type 00101, data E5E5) → `fault_vld` exactly once with `RX_CONFIRM_EN`, six times without it. Same burst with data E5E4 → six `frame_err` pulses, no `fault_vld`.
- Frame with type 00011 and valid parity → `frame_err`, no `_vld`.
- `rst_n` low at bit 10 of a state frame, released, then a full state frame with 16'h0F0F → no pulse from the aborted frame; the next frame decodes to `state`=16'h0F0F.
